// File: rtl/calc_pkg.sv
// Shared constants for the calculator control-path counters:
// mode encoding and the per-edge count operation codes.
package calc_pkg;

  localparam logic MODE_SAT  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_UP   = 3'd1;
  localparam logic [2:0] OP_DOWN = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;
  localparam logic [2:0] OP_FIX  = 3'd4;

endpackage

// File: rtl/load_reg.sv
// W-bit register with synchronous reset to a parameterised value
// and a load enable; holds its value otherwise.
module load_reg #(
  parameter int           W       = 5,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_q <= RST_VAL;
    else if (i_load)
      o_q <= i_d;
  end

endmodule

// File: rtl/bounded_updown_counter.sv
// Up/down counter bounded by runtime-loadable min/max registers, with a
// programmable step, saturate or wrap mode, and wrap/err event pulses.
module bounded_updown_counter
  import calc_pkg::*;
#(
  parameter int           N       = 5,
  parameter logic [N-1:0] RST_MAX = {N{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up,
  input  logic         down,
  input  logic         ldcnt,
  input  logic         ldmin,
  input  logic         ldmax,
  input  logic         mode,
  input  logic [N-1:0] step,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] min_q,
  output logic [N-1:0] max_q,
  output logic         at_min,
  output logic         at_max,
  output logic         wrap,
  output logic         err
);

  logic [N-1:0] r_out;
  logic         r_wrap;
  logic         r_err;

  logic [2:0]   w_op;
  logic [N:0]   w_sum;
  logic [N:0]   w_span;
  logic [N-1:0] w_nextOut;
  logic         w_nextWrap;
  logic         w_minLoad;
  logic         w_maxLoad;
  logic         w_nextErr;

  // A simultaneous min/max load collapses the range to one point and is
  // always legal; a lone load must not cross the other bound.
  assign w_minLoad = ldmin & (ldmax | (in <= max_q));
  assign w_maxLoad = ldmax & (ldmin | (in >= min_q));
  assign w_nextErr = (ldmin & ~ldmax & (in > max_q)) | (ldmax & ~ldmin & (in < min_q));

  load_reg #(.W(N), .RST_VAL('0)) u_minReg (
    .i_clk (clk),
    .i_rst (rst),
    .i_load(w_minLoad),
    .i_d   (in),
    .o_q   (min_q)
  );

  load_reg #(.W(N), .RST_VAL(RST_MAX)) u_maxReg (
    .i_clk (clk),
    .i_rst (rst),
    .i_load(w_maxLoad),
    .i_d   (in),
    .o_q   (max_q)
  );

  // An out-of-range count is pulled back before any up/down is honoured.
  always_comb begin
    w_op = OP_HOLD;
    if (ldcnt)
      w_op = OP_LOAD;
    else if ((r_out < min_q) || (r_out > max_q))
      w_op = OP_FIX;
    else if ((up ^ down) && (step != '0))
      w_op = up ? OP_UP : OP_DOWN;
  end

  assign w_sum  = {1'b0, r_out} + {1'b0, step};
  assign w_span = {1'b0, r_out} - {1'b0, min_q};

  always_comb begin
    w_nextOut  = r_out;
    w_nextWrap = 1'b0;
    case (w_op)
      OP_LOAD: begin
        if (in < min_q)
          w_nextOut = min_q;
        else if (in > max_q)
          w_nextOut = max_q;
        else
          w_nextOut = in;
      end
      OP_FIX: w_nextOut = (r_out < min_q) ? min_q : max_q;
      OP_UP: begin
        if (w_sum > {1'b0, max_q}) begin
          w_nextOut  = (mode == MODE_WRAP) ? min_q : max_q;
          w_nextWrap = (mode == MODE_WRAP);
        end else begin
          w_nextOut = w_sum[N-1:0];
        end
      end
      OP_DOWN: begin
        // w_span is only used when the count is in range, so it never underflows.
        if ({1'b0, step} > w_span) begin
          w_nextOut  = (mode == MODE_WRAP) ? max_q : min_q;
          w_nextWrap = (mode == MODE_WRAP);
        end else begin
          w_nextOut = r_out - step;
        end
      end
      default: w_nextOut = r_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_out  <= w_nextOut;
      r_wrap <= w_nextWrap;
      r_err  <= w_nextErr;
    end
  end

  assign out    = r_out;
  assign wrap   = r_wrap;
  assign err    = r_err;
  assign at_min = (r_out == min_q);
  assign at_max = (r_out == max_q);

endmodule
